// File: rtl/scoring_pkg.sv
// Widths, score type and streamer state encoding shared between the frame
// streamer and the frame scorer.
package scoring_pkg;

    localparam int unsigned HRES   = 320;
    localparam int unsigned VRES   = 180;
    localparam int unsigned HWIDTH = $clog2(HRES);
    localparam int unsigned VWIDTH = $clog2(VRES);
    localparam int unsigned DWIDTH = $clog2(HRES + VRES + 1);
    localparam int unsigned AWIDTH = $clog2(HRES * VRES);

    typedef logic [2:0] score_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StWaitScore
    } stream_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter with wrap, synchronous clear and a last-pixel flag.
module raster_counter #(
    parameter int unsigned HRES = 320,
    parameter int unsigned VRES = 180,
    localparam int unsigned HWIDTH = $clog2(HRES),
    localparam int unsigned VWIDTH = $clog2(VRES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic [HWIDTH-1:0] h,
    output logic [VWIDTH-1:0] v,
    output logic              last
);

    localparam logic [HWIDTH-1:0] HMAX = HWIDTH'(HRES - 1);
    localparam logic [VWIDTH-1:0] VMAX = VWIDTH'(VRES - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            h <= '0;
            v <= '0;
        end else if (step) begin
            if (h == HMAX) begin
                h <= '0;
                v <= (v == VMAX) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign last = (h == HMAX) && (v == VMAX);

endmodule

// File: rtl/score_frame_streamer.sv
// Raster-scans the skeleton/distance buffers into the frame scorer, then waits
// for the scorer's end-of-frame result and reports done or timeout.
module score_frame_streamer #(
    parameter int unsigned HRES           = scoring_pkg::HRES,
    parameter int unsigned VRES           = scoring_pkg::VRES,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    localparam int unsigned HWIDTH = $clog2(HRES),
    localparam int unsigned VWIDTH = $clog2(VRES),
    localparam int unsigned DWIDTH = $clog2(HRES + VRES + 1),
    localparam int unsigned AWIDTH = $clog2(HRES * VRES)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    output logic [AWIDTH-1:0]   addr_out,
    input  logic                skel_data_in,
    input  logic [DWIDTH-1:0]   dist_data_in,
    output logic [HWIDTH-1:0]   hcount_out,
    output logic [VWIDTH-1:0]   vcount_out,
    output logic                skeleton_bit_out,
    output logic [DWIDTH-1:0]   pixel_distance_out,
    output logic                valid_out,
    input  logic                score_valid_in,
    input  scoring_pkg::score_t score_in,
    output logic                busy_out,
    output scoring_pkg::score_t score_out,
    output logic                done_out,
    output logic                timeout_out
);

    import scoring_pkg::*;

    localparam int unsigned NPIX   = HRES * VRES;
    localparam int unsigned TWIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CWIDTH = $clog2(READ_LATENCY + 1);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NPIX - 1);

    stream_state_t     state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [CWIDTH-1:0] drain_q, drain_d;
    logic [TWIDTH-1:0] tcnt_q, tcnt_d;
    logic              pend_q, pend_d;
    score_t            pend_score_q, pend_score_d;
    score_t            score_q, score_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              raster_clear, raster_step, raster_last;
    logic [HWIDTH-1:0] scan_h;
    logic [VWIDTH-1:0] scan_v;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [HWIDTH-1:0]       h_pipe [READ_LATENCY];
    logic [VWIDTH-1:0]       v_pipe [READ_LATENCY];

    logic              valid_q, skel_q;
    logic [HWIDTH-1:0] hcount_q;
    logic [VWIDTH-1:0] vcount_q;
    logic [DWIDTH-1:0] dist_q;

    raster_counter #(
        .HRES (HRES),
        .VRES (VRES)
    ) u_raster (
        .clk   (clk_in),
        .rst   (rst_in),
        .clear (raster_clear),
        .step  (raster_step),
        .h     (scan_h),
        .v     (scan_v),
        .last  (raster_last)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        drain_d      = drain_q;
        tcnt_d       = tcnt_q;
        pend_d       = pend_q;
        pend_score_d = pend_score_q;
        score_d      = score_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        raster_clear = 1'b0;
        raster_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // busy_q still high on the done/timeout cycle blocks a restart there
                if (start_in && !busy_q) begin
                    state_d      = StScan;
                    addr_d       = '0;
                    raster_clear = 1'b1;
                    pend_d       = 1'b0;
                end
            end
            StScan: begin
                raster_step = 1'b1;
                if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                if (raster_last) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (drain_q == CWIDTH'(READ_LATENCY)) begin
                    state_d = StWaitScore;
                    tcnt_d  = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StWaitScore: begin
                if (pend_q || score_valid_in) begin
                    score_d = pend_q ? pend_score_q : score_in;
                    done_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = StIdle;
                end else if (tcnt_q == TWIDTH'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // An early result is held until the stream has fully drained.
        if ((state_q == StScan || state_q == StDrain) && score_valid_in) begin
            pend_d       = 1'b1;
            pend_score_d = score_in;
        end
        busy_d = (state_d != StIdle) || done_d || timeout_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            drain_q      <= '0;
            tcnt_q       <= '0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            score_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drain_q      <= drain_d;
            tcnt_q       <= tcnt_d;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            score_q      <= score_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    always_ff @(posedge clk_in) begin
        h_pipe[0] <= scan_h;
        v_pipe[0] <= scan_v;
        for (int i = 1; i < READ_LATENCY; i++) begin
            h_pipe[i] <= h_pipe[i-1];
            v_pipe[i] <= v_pipe[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe <= '0;
            valid_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            skel_q   <= 1'b0;
            dist_q   <= '0;
        end else begin
            vld_pipe[0] <= (state_q == StScan);
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            valid_q <= vld_pipe[READ_LATENCY-1];
            if (vld_pipe[READ_LATENCY-1]) begin
                hcount_q <= h_pipe[READ_LATENCY-1];
                vcount_q <= v_pipe[READ_LATENCY-1];
                skel_q   <= skel_data_in;
                dist_q   <= dist_data_in;
            end
        end
    end

    assign addr_out           = addr_q;
    assign hcount_out         = hcount_q;
    assign vcount_out         = vcount_q;
    assign skeleton_bit_out   = skel_q;
    assign pixel_distance_out = dist_q;
    assign valid_out          = valid_q;
    assign busy_out           = busy_q;
    assign score_out          = score_q;
    assign done_out           = done_q;
    assign timeout_out        = timeout_q;

endmodule

// File: tb/tb_score_frame_streamer.sv
// Bench for score_frame_streamer on an 8x4 frame with a latency-2 buffer model
// and a scheduled scorer response.
module tb_score_frame_streamer;

    localparam int HRES = 8;
    localparam int VRES = 4;
    localparam int RL   = 2;
    localparam int TMO  = 15;
    localparam int NPIX = HRES * VRES;
    localparam int HW   = $clog2(HRES);
    localparam int VW   = $clog2(VRES);
    localparam int DW   = $clog2(HRES + VRES + 1);
    localparam int AW   = $clog2(NPIX);
    // Offsets from the cycle start is sampled.
    localparam int FIRST_OFF = RL + 1;
    localparam int ENTRY_OFF = FIRST_OFF + NPIX;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          score_valid = 1'b0;
    logic [2:0]    score_in = '0;
    logic [AW-1:0] addr;
    logic          skel_data;
    logic [DW-1:0] dist_data;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          skel_bit;
    logic [DW-1:0] pix_dist;
    logic          valid, busy, done, timeout;
    logic [2:0]    score_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [2:0] exp_score = '0;

    score_frame_streamer #(
        .HRES           (HRES),
        .VRES           (VRES),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .start_in           (start),
        .addr_out           (addr),
        .skel_data_in       (skel_data),
        .dist_data_in       (dist_data),
        .hcount_out         (hcount),
        .vcount_out         (vcount),
        .skeleton_bit_out   (skel_bit),
        .pixel_distance_out (pix_dist),
        .valid_out          (valid),
        .score_valid_in     (score_valid),
        .score_in           (score_in),
        .busy_out           (busy),
        .score_out          (score_o),
        .done_out           (done),
        .timeout_out        (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: dist = addr (truncated to DW bits), skel = addr[0], RL cycles late.
    logic [AW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= addr;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign skel_data = rd_pipe[RL-1][0];
    assign dist_data = rd_pipe[RL-1][DW-1:0];

    typedef struct {
        logic [31:0] c;
        logic [31:0] h;
        logic [31:0] v;
        logic [31:0] d;
        logic [31:0] s;
    } beat_t;

    beat_t beats[$];
    int    done_c[$];
    int    done_s[$];
    int    to_c[$];
    int    rise_c[$];
    int    fall_c[$];
    logic  prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid === 1'b1)
                beats.push_back('{32'(cyc), 32'(hcount), 32'(vcount), 32'(pix_dist),
                                  32'(skel_bit)});
            if (done === 1'b1) begin
                done_c.push_back(cyc);
                done_s.push_back(int'(score_o));
            end
            if (timeout === 1'b1) to_c.push_back(cyc);
            if (busy === 1'b1 && !prev_busy) rise_c.push_back(cyc);
            if (busy === 1'b0 && prev_busy) fall_c.push_back(cyc);
        end
        prev_busy = busy;
    end

    task automatic clear_logs();
        beats.delete();
        done_c.delete();
        done_s.delete();
        to_c.delete();
        rise_c.delete();
        fall_c.delete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        start = 1'b0;
    endtask

    task automatic drive_score_at(input int c, input logic [2:0] sc);
        wait_until(c);
        score_valid = 1'b1;
        score_in    = sc;
        @(posedge clk);
        #1 score_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid_busy: got valid=%b busy=%b, want 0 0", valid, busy);
        end
        n_cmp++;
        if (done !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses: got done=%b timeout=%b, want 0 0", done, timeout);
        end
        n_cmp++;
        if (score_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_score: got %0d, want 0", score_o);
        end
        n_cmp++;
        if ({addr, hcount, vcount, skel_bit, pix_dist} !== '0) begin
            n_err++;
            $display("FAIL reset_stream: got addr=%0d h=%0d v=%0d skel=%b dist=%0d, want all 0",
                     addr, hcount, vcount, skel_bit, pix_dist);
        end
        rst = 1'b0;
        exp_score = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One full frame; r_off < 0 means the scorer never answers.
    task automatic test_stream(input string name, input int r_off, input logic [2:0] sc);
        int s, first, entry, done_exp, to_exp, end_pulse;
        bit exp_done;
        clear_logs();
        pulse_start(s);
        first = s + FIRST_OFF;
        entry = s + ENTRY_OFF;
        if (r_off >= 0) drive_score_at(s + r_off, sc);
        wait_until(entry + TMO + 5);

        exp_done = (r_off >= 0) && (r_off < ENTRY_OFF + TMO);
        done_exp = (r_off < ENTRY_OFF) ? entry + 1 : s + r_off + 1;
        to_exp   = entry + TMO;
        if (exp_done) exp_score = sc;
        end_pulse = exp_done ? done_exp : to_exp;

        n_cmp++;
        if (beats.size() != NPIX) begin
            n_err++;
            $display("FAIL %s beat_count: got %0d, want %0d", name, beats.size(), NPIX);
        end
        foreach (beats[i]) begin
            n_cmp++;
            if (beats[i].c !== 32'(first + i) || beats[i].h !== 32'(i % HRES)
                || beats[i].v !== 32'(i / HRES) || beats[i].d !== 32'(i % (1 << DW))
                || beats[i].s !== 32'(i % 2)) begin
                n_err++;
                $display("FAIL %s beat%0d: got c=%0d h=%0d v=%0d d=%0d s=%0d, want c=%0d h=%0d v=%0d d=%0d s=%0d",
                         name, i, beats[i].c, beats[i].h, beats[i].v, beats[i].d, beats[i].s,
                         first + i, i % HRES, i / HRES, i % (1 << DW), i % 2);
            end
        end
        n_cmp++;
        if (done_c.size() != (exp_done ? 1 : 0) || to_c.size() != (exp_done ? 0 : 1)) begin
            n_err++;
            $display("FAIL %s pulse_count: got done=%0d timeout=%0d, want done=%0d timeout=%0d",
                     name, done_c.size(), to_c.size(), exp_done ? 1 : 0, exp_done ? 0 : 1);
        end
        if (exp_done && done_c.size() == 1) begin
            n_cmp++;
            if (done_c[0] != done_exp || done_s[0] != int'(sc)) begin
                n_err++;
                $display("FAIL %s done: got cycle=%0d score=%0d, want cycle=%0d score=%0d",
                         name, done_c[0] - s, done_s[0], done_exp - s, sc);
            end
        end
        if (!exp_done && to_c.size() == 1) begin
            n_cmp++;
            if (to_c[0] != to_exp) begin
                n_err++;
                $display("FAIL %s timeout_cycle: got %0d, want %0d", name, to_c[0] - s, to_exp - s);
            end
        end
        n_cmp++;
        if (rise_c.size() != 1 || fall_c.size() != 1
            || (rise_c.size() == 1 && rise_c[0] != s)
            || (fall_c.size() == 1 && fall_c[0] != end_pulse + 1)) begin
            n_err++;
            $display("FAIL %s busy_window: got rises=%0d falls=%0d first_rise=%0d first_fall=%0d, want rise=%0d fall=%0d",
                     name, rise_c.size(), fall_c.size(),
                     rise_c.size() > 0 ? rise_c[0] - s : -1,
                     fall_c.size() > 0 ? fall_c[0] - s : -1, 0, end_pulse + 1 - s);
        end
        n_cmp++;
        if (score_o !== exp_score) begin
            n_err++;
            $display("FAIL %s score_out: got %0d, want %0d", name, score_o, exp_score);
        end
    endtask

    task automatic test_start_spam();
        int s;
        clear_logs();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        repeat (NPIX) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        drive_score_at(s + ENTRY_OFF + 3, 3'd6);
        exp_score = 3'd6;
        wait_until(s + ENTRY_OFF + TMO + 5);
        n_cmp++;
        if (beats.size() != NPIX || done_c.size() != 1 || to_c.size() != 0) begin
            n_err++;
            $display("FAIL spam_counts: got beats=%0d done=%0d timeout=%0d, want %0d 1 0",
                     beats.size(), done_c.size(), to_c.size(), NPIX);
        end
        n_cmp++;
        if (beats.size() > 0 && beats[0].c !== 32'(s + FIRST_OFF)) begin
            n_err++;
            $display("FAIL spam_first_beat: got cycle %0d, want %0d", beats[0].c - s, FIRST_OFF);
        end
    endtask

    task automatic test_back_to_back();
        int s, entry;
        clear_logs();
        pulse_start(s);
        entry = s + ENTRY_OFF;
        drive_score_at(entry + 3, 3'd1);
        exp_score = 3'd1;
        // start coincides with the done pulse and must be dropped
        wait_until(entry + 4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (beats.size() != NPIX || done_c.size() != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_cycle_start: got beats=%0d done=%0d busy=%b, want %0d 1 0",
                     beats.size(), done_c.size(), busy, NPIX);
        end
        test_stream("second_frame", ENTRY_OFF + 3, 3'd4);
    endtask

    task automatic test_reset_mid();
        int s;
        clear_logs();
        pulse_start(s);
        wait_until(s + FIRST_OFF + 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0
            || score_o !== 3'd0 || {addr, hcount, vcount, skel_bit, pix_dist} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got valid=%b busy=%b done=%b to=%b score=%0d addr=%0d h=%0d v=%0d, want all 0",
                     valid, busy, done, timeout, score_o, addr, hcount, vcount);
        end
        exp_score = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        repeat (ENTRY_OFF + TMO + 5) @(posedge clk);
        #1;
        n_cmp++;
        if (beats.size() != 0 || done_c.size() != 0 || to_c.size() != 0) begin
            n_err++;
            $display("FAIL midreset_silence: got beats=%0d done=%0d timeout=%0d, want 0 0 0",
                     beats.size(), done_c.size(), to_c.size());
        end
        test_stream("after_reset", ENTRY_OFF + 2, 3'd7);
    endtask

    task automatic test_random_arrival();
        for (int k = 0; k < 6; k++) begin
            int r;
            logic [2:0] sc;
            r  = int'($urandom_range(0, ENTRY_OFF + TMO + 3));
            sc = 3'($urandom);
            test_stream($sformatf("random%0d_r%0d", k, r), r, sc);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream("frame", ENTRY_OFF + 3, 3'd5);
        test_stream("timeout", -1, 3'd0);
        test_start_spam();
        test_back_to_back();
        test_reset_mid();
        test_stream("drain_score", NPIX + 1, 3'd2);
        test_stream("expiry_score", ENTRY_OFF + TMO - 1, 3'd3);
        test_random_arrival();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
